// File: rtl/rdop_ctrl_responder_pkg.sv
// rdop_ctrl_responder_pkg: RDOP protocol constants, register map and responder states
package rdop_ctrl_responder_pkg;
    localparam logic [7:0]  OP_RDOP   = 8'h4E;
    localparam logic [15:0] DMU_LSB   = 16'h0012;
    localparam logic [15:0] DMU_MSB   = 16'h0013;
    localparam logic [15:0] EMPTY_PAT = 16'hFFFF;
    localparam logic [15:0] UNMAPPED  = 16'hF001;
    localparam logic [7:0] REG_STATUS  = 8'h00;
    localparam logic [7:0] REG_CTRL    = 8'h01;
    localparam logic [7:0] REG_CMD     = 8'h02;
    localparam logic [7:0] REG_CHIPID  = 8'h03;
    localparam logic [7:0] REG_LATENCY = 8'h04;
    localparam logic [7:0] REG_PUSH_LO = 8'h05;
    localparam logic [7:0] REG_PUSH_HI = 8'h06;
    localparam logic [7:0] REG_ERR_CNT = 8'h07;
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_ACK = 2'd2} state_t;
endpackage

// File: rtl/evt_word_fifo.sv
// evt_word_fifo: synchronous 24-bit event-word FIFO with flush; push while full only lands with a same-cycle pop
module evt_word_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [23:0]           wdata,
    input  logic                  pop,
    input  logic                  flush,
    output logic [23:0]           rdata,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level
);
    logic [23:0] mem [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] wptr, rptr;
    logic do_push, do_pop;

    assign full    = level == (DEPTH_LOG2+1)'(2**DEPTH_LOG2);
    assign empty   = level == '0;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr];

    always_ff @(posedge clk)
        if (do_push)
            mem[wptr] <= wdata;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            wptr  <= wptr + DEPTH_LOG2'(do_push);
            rptr  <= rptr + DEPTH_LOG2'(do_pop);
            level <= level + (DEPTH_LOG2+1)'(do_push) - (DEPTH_LOG2+1)'(do_pop);
        end
    end
endmodule

// File: rtl/rdop_ctrl_responder.sv
// rdop_ctrl_responder: ALPIDE-style control-port responder answering RDOP reads of the DMU FIFO
// from an internal event-word FIFO, with a programmable ack latency and a small register file.
module rdop_ctrl_responder
    import rdop_ctrl_responder_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int LAT_W      = 8
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        reg_we_i,
    input  logic [7:0]  reg_addr_i,
    input  logic [15:0] reg_data_i,
    output logic [15:0] reg_data_o,
    input  logic [7:0]  ctrl_opcode_i,
    input  logic [7:0]  ctrl_chipid_i,
    input  logic [15:0] ctrl_addr_i,
    input  logic        ctrl_rd_i,
    output logic [15:0] ctrl_data_o,
    output logic        ctrl_ack_o,
    input  logic [23:0] push_data_i,
    input  logic        push_we_i,
    output logic        fifo_full_o
);
    state_t state, state_nxt;
    logic [LAT_W-1:0] cnt, latency;
    logic [7:0] chipid, opcode;
    logic [15:0] addr, err_cnt, push_lo, resp;
    logic enable, ovf;
    logic fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty, reg_push;
    logic [23:0] fifo_wdata, head;
    logic [DEPTH_LOG2:0] level;
    logic is_ack, bad_op, dmu, empty_err, capture;

    evt_word_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
        .clk   (clk_i),
        .rst_n (rst_n_i),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .flush (fifo_flush),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    // The push port wins over a same-cycle PUSH_HI write; the loser is flagged through ovf
    assign reg_push   = reg_we_i && reg_addr_i == REG_PUSH_HI;
    assign fifo_push  = push_we_i || reg_push;
    assign fifo_wdata = push_we_i ? push_data_i : {reg_data_i[7:0], push_lo};
    assign fifo_flush = reg_we_i && reg_addr_i == REG_CMD && reg_data_i == '0;
    assign fifo_full_o = fifo_full;

    assign is_ack    = state == S_ACK;
    assign bad_op    = opcode != OP_RDOP;
    assign dmu       = addr == DMU_LSB || addr == DMU_MSB;
    assign empty_err = !bad_op && dmu && fifo_empty;
    assign resp      = bad_op ? 16'h0000 :
                       empty_err ? EMPTY_PAT :
                       addr == DMU_LSB ? head[15:0] :
                       addr == DMU_MSB ? {8'h00, head[23:16]} : 16'h0000;
    assign ctrl_ack_o  = is_ack;
    assign ctrl_data_o = is_ack ? resp : 16'h0000;
    assign fifo_pop    = is_ack && !bad_op && addr == DMU_MSB && !fifo_empty;
    assign capture     = state == S_IDLE && state_nxt != S_IDLE;

    // Latency 0 skips WAIT so the ack lands in the cycle right after capture
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (enable && ctrl_rd_i && ctrl_chipid_i == chipid)
                         state_nxt = (latency == '0) ? S_ACK : S_WAIT;
            S_WAIT:  if (!enable || !ctrl_rd_i) state_nxt = S_IDLE;
                     else if (cnt == LAT_W'(1)) state_nxt = S_ACK;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state   <= S_IDLE;
            cnt     <= '0;
            opcode  <= '0;
            addr    <= '0;
            chipid  <= 8'h10;
            latency <= LAT_W'(2);
            enable  <= 1'b0;
            err_cnt <= '0;
            ovf     <= 1'b0;
            push_lo <= '0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                opcode <= ctrl_opcode_i;
                addr   <= ctrl_addr_i;
                cnt    <= latency;
            end else if (state == S_WAIT) begin
                cnt <= cnt - LAT_W'(1);
            end
            if (reg_we_i && reg_addr_i == REG_CTRL)    enable  <= reg_data_i[0];
            if (reg_we_i && reg_addr_i == REG_CHIPID)  chipid  <= reg_data_i[7:0];
            if (reg_we_i && reg_addr_i == REG_LATENCY) latency <= reg_data_i[LAT_W-1:0];
            if (reg_we_i && reg_addr_i == REG_PUSH_LO) push_lo <= reg_data_i;
            if (is_ack && (bad_op || empty_err) && err_cnt != 16'hFFFF)
                err_cnt <= err_cnt + 16'd1;
            if (fifo_flush)
                ovf <= 1'b0;
            else if ((push_we_i && reg_push) || (fifo_push && fifo_full && !fifo_pop))
                ovf <= 1'b1;
        end
    end

    always_comb begin
        reg_data_o = UNMAPPED;
        unique case (reg_addr_i)
            REG_STATUS:  reg_data_o = 16'({ovf, state, level});
            REG_CTRL:    reg_data_o = {15'h0000, enable};
            REG_CMD:     reg_data_o = 16'h0000;
            REG_CHIPID:  reg_data_o = {8'h00, chipid};
            REG_LATENCY: reg_data_o = 16'(latency);
            REG_PUSH_LO: reg_data_o = push_lo;
            REG_PUSH_HI: reg_data_o = 16'h0000;
            REG_ERR_CNT: reg_data_o = err_cnt;
            default:     reg_data_o = UNMAPPED;
        endcase
    end
endmodule
